// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address-field width helpers for the instruction cache.
// Exports state_t (IDLE/REFILL/DRAIN) and off_w/idx_w/tag_w width functions.
// Fetch addresses are byte addresses; bits [1:0] never take part in lookup.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Word-offset field width within a line.
    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    // Line-index field width.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: whatever is left of the 30-bit word address.
    function automatic int tag_w(input int lines, input int words);
        return 30 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_store.sv
// icache_store: valid/tag/data arrays for a direct-mapped cache, zero-latency read.
// Ports: read (rd_idx, rd_word -> rd_valid, rd_tag, rd_data); write (wr_en, wr_idx, wr_word, wr_data;
// fill_en also writes fill_tag and sets valid); inv_en/inv_idx single-line clear; inv_all bulk clear.
module icache_store
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int IW    = idx_w(LINES),
    parameter int OW    = off_w(WORDS),
    parameter int TW    = tag_w(LINES, WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] rd_idx,
    input  logic [OW-1:0] rd_word,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [OW-1:0] wr_word,
    input  logic [31:0]   wr_data,
    input  logic          fill_en,
    input  logic [TW-1:0] fill_tag,
    input  logic          inv_en,
    input  logic [IW-1:0] inv_idx,
    input  logic          inv_all
);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      data [LINES][WORDS];

    // Bulk invalidate is last so it wins over a line completing the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (inv_en)  valid[inv_idx] <= 1'b0;
            if (fill_en) valid[wr_idx]  <= 1'b1;
            if (inv_all) valid          <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)   data[wr_idx][wr_word] <= wr_data;
        if (fill_en) tags[wr_idx]          <= fill_tag;
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx][rd_word];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache; hits return combinationally in the request cycle.
// Ports: fetch side instradr/instrreq/abort/flush -> instr/hit; memory side memreq/memadr <- memdata/memval.
// Refill fetches one word at a time, memreq held until memval. ICACHE_STATS_EN adds hitcnt/misscnt.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instradr,
    input  logic        instrreq,
    output logic [31:0] instr,
    output logic        hit,
    input  logic        abort,
    input  logic        flush,
    output logic [31:0] memadr,
    output logic        memreq,
    input  logic [31:0] memdata,
    input  logic        memval
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hitcnt,
    output logic [31:0] misscnt
`endif
);

    localparam int OW = off_w(WORDS);
    localparam int IW = idx_w(LINES);
    localparam int TW = tag_w(LINES, WORDS);

    state_t        state;
    logic [OW-1:0] wordcnt;
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          flush_pending;

    logic [OW-1:0] a_word;
    logic [IW-1:0] a_idx;
    logic [TW-1:0] a_tag;
    logic          unused_bytesel;

    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    logic [31:0]   rd_data;

    logic lookup;
    logic tag_ok;
    logic miss;
    logic mem_ack;
    logic last;
    logic accept;
    logic to_idle;
    logic inv_all;

    assign a_word         = instradr[2 +: OW];
    assign a_idx          = instradr[2 + OW +: IW];
    assign a_tag          = instradr[31 -: TW];
    assign unused_bytesel = ^instradr[1:0];

    // A lookup only happens in IDLE for a live, un-cancelled, un-flushed request.
    assign lookup  = (state == IDLE) && instrreq && !abort && !flush && !reset;
    assign tag_ok  = rd_valid && (rd_tag == a_tag);
    assign hit     = lookup && tag_ok;
    assign miss    = lookup && !tag_ok;
    assign instr   = hit ? rd_data : 32'd0;

    assign mem_ack = memreq && memval;
    assign last    = (wordcnt == OW'(WORDS - 1));
    // An abort in the same cycle as memval drops the word.
    assign accept  = (state == REFILL) && mem_ack && !abort;

    assign to_idle = ((state == REFILL) && mem_ack && (last || abort))
                   || ((state == DRAIN) && mem_ack);

    // Flushes seen outside IDLE are applied on the edge that returns to IDLE,
    // which also kills a line completing on that same edge.
    assign inv_all = !reset && (((state == IDLE) && flush)
                   || (to_idle && (flush_pending || flush)));

    icache_store #(
        .LINES (LINES),
        .WORDS (WORDS),
        .IW    (IW),
        .OW    (OW),
        .TW    (TW)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (a_idx),
        .rd_word  (a_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (accept),
        .wr_idx   (fill_idx),
        .wr_word  (wordcnt),
        .wr_data  (memdata),
        .fill_en  (accept && last),
        .fill_tag (fill_tag),
        .inv_en   (miss),
        .inv_idx  (a_idx),
        .inv_all  (inv_all)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            memreq        <= 1'b0;
            memadr        <= 32'd0;
            wordcnt       <= '0;
            fill_idx      <= '0;
            fill_tag      <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (to_idle)
                flush_pending <= 1'b0;
            else if ((state != IDLE) && flush)
                flush_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (miss) begin
                        state    <= REFILL;
                        memreq   <= 1'b1;
                        memadr   <= {instradr[31:OW+2], {(OW+2){1'b0}}};
                        wordcnt  <= '0;
                        fill_idx <= a_idx;
                        fill_tag <= a_tag;
                    end
                end
                REFILL: begin
                    if (abort) begin
                        // Handshake in flight must still complete before IDLE.
                        if (mem_ack) begin
                            state  <= IDLE;
                            memreq <= 1'b0;
                        end else begin
                            state  <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        wordcnt <= wordcnt + 1'b1;
                        memadr  <= memadr + 32'd4;
                        if (last) begin
                            state  <= IDLE;
                            memreq <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state  <= IDLE;
                        memreq <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memreq <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hitcnt  <= 32'd0;
            misscnt <= 32'd0;
        end else begin
            if (hit)  hitcnt  <= hitcnt + 32'd1;
            if (miss) misscnt <= misscnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache (LINES=16, WORDS=4).
// Memory responder and line-residency reference model live in the bench.
// Table vectors, hand sequences for abort/flush/reset, then randomized fetches.
module tb_icache;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instradr;
    logic        instrreq;
    logic [31:0] instr;
    logic        hit;
    logic        abort;
    logic        flush;
    logic [31:0] memadr;
    logic        memreq;
    logic [31:0] memdata;
    logic        memval;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitcnt;
    logic [31:0] misscnt;
`endif

    always #5 clk = ~clk;

    icache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .instradr (instradr),
        .instrreq (instrreq),
        .instr    (instr),
        .hit      (hit),
        .abort    (abort),
        .flush    (flush),
        .memadr   (memadr),
        .memreq   (memreq),
        .memdata  (memdata),
        .memval   (memval)
`ifdef ICACHE_STATS_EN
        ,
        .hitcnt   (hitcnt),
        .misscnt  (misscnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    bit mem_auto  = 1'b1;
    bit mem_rand  = 1'b0;
    int mem_delay = 0;
    int wcnt      = 0;

    bit          m_val [LINES];
    int unsigned m_tag [LINES];

    typedef struct {
        logic [31:0] adr;
        bit          exp_miss;
    } vec_t;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    // One clock; afterwards the memory model reacts to the post-edge memreq/memadr.
    task automatic tick();
        int d;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            d = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
            if (memval) begin
                memval = 1'b0;
                wcnt   = 0;
            end
            if (memreq) begin
                if (wcnt >= d) begin
                    memval  = 1'b1;
                    memdata = memfn(memadr);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        instrreq = 1'b0;
        abort    = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Issue one fetch and hold it until hit; checks refill word order and memreq hold.
    task automatic fetch(input logic [31:0] adr, input bit exp_miss, input string nm);
        logic [31:0] base;
        int k;
        bit req_ok;
        bit done;
        base     = adr & ~32'(WORDS * 4 - 1);
        k        = 0;
        req_ok   = 1'b1;
        done     = 1'b0;
        instradr = adr;
        instrreq = 1'b1;
        #1;
        chk_b({nm, "/first_hit"}, hit, !exp_miss);
        if (!hit) begin
            for (int cyc = 0; cyc < 100 && !done; cyc++) begin
                tick();
                #1;
                if (hit) begin
                    done = 1'b1;
                end else begin
                    if (!memreq) req_ok = 1'b0;
                    if (memreq && memval) begin
                        chk({nm, "/memadr"}, memadr, base + 32'(4 * k));
                        k++;
                    end
                end
            end
            chk_b({nm, "/hit_after_fill"}, done, 1'b1);
            chk({nm, "/words"}, 32'(k), 32'(WORDS));
            chk_b({nm, "/memreq_held"}, req_ok, 1'b1);
        end
        chk({nm, "/instr"}, instr, memfn(adr & ~32'd3));
        tick();
        instrreq = 1'b0;
    endtask

    // Run the refill until handshake number 'target' is visible this cycle.
    task automatic wait_acks(input int target, inout int k);
        for (int cyc = 0; cyc < 60 && k < target; cyc++) begin
            tick();
            #1;
            if (memreq && memval) k++;
        end
    endtask

    initial begin
        vec_t        vecs [10];
        int          k;
        bit          ok;
        bit          drained;
        logic [31:0] adr;
        int unsigned line, idx, tg;
        int unsigned tag_pool [4];

        vecs[0] = '{32'h0000_0040, 1'b1};
        vecs[1] = '{32'h0000_0048, 1'b0};
        vecs[2] = '{32'h0000_004F, 1'b0};
        vecs[3] = '{32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_0100, 1'b1};
        vecs[5] = '{32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_0004, 1'b0};
        vecs[7] = '{32'h0000_0140, 1'b1};
        vecs[8] = '{32'h0000_0044, 1'b1};
        vecs[9] = '{32'h0000_004C, 1'b0};

        tag_pool[0] = 0;
        tag_pool[1] = 1;
        tag_pool[2] = 5;
        tag_pool[3] = 32'h00FF_FFFF;

        reset    = 1'b1;
        instradr = 32'd0;
        instrreq = 1'b0;
        abort    = 1'b0;
        flush    = 1'b0;
        memval   = 1'b0;
        memdata  = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        #1;

        chk_b("rst/hit", hit, 1'b0);
        chk("rst/instr", instr, 32'd0);
        chk_b("rst/memreq", memreq, 1'b0);
        chk("rst/memadr", memadr, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rst/hitcnt", hitcnt, 32'd0);
        chk("rst/misscnt", misscnt, 32'd0);
`endif

        // Cold miss, hits in the same line, conflict evictions.
        mem_delay = 1;
        for (int i = 0; i < 10; i++)
            fetch(vecs[i].adr, vecs[i].exp_miss, $sformatf("vec%0d", i));

        // Abort after the 2nd word while the 3rd is delayed 3 cycles.
        mem_delay = 0;
        k         = 0;
        instradr  = 32'h0000_0200;
        instrreq  = 1'b1;
        #1;
        chk_b("abort/miss", hit, 1'b0);
        wait_acks(2, k);
        instrreq  = 1'b0;
        mem_delay = 3;
        tick();
        #1;
        chk("abort/pre_adr", memadr, 32'h0000_0208);
        abort = 1'b1;
        #1;
        chk_b("abort/hit", hit, 1'b0);
        tick();
        abort = 1'b0;
        #1;
        ok      = 1'b1;
        drained = 1'b0;
        for (int cyc = 0; cyc < 20 && !drained; cyc++) begin
            if (!memreq || memadr != 32'h0000_0208) ok = 1'b0;
            if (memval) drained = 1'b1;
            else begin
                tick();
                #1;
            end
        end
        chk_b("drain/held", ok, 1'b1);
        chk_b("drain/done", drained, 1'b1);
        tick();
        #1;
        chk_b("drain/exit_req", memreq, 1'b0);
        mem_delay = 0;
        fetch(32'h0000_0200, 1'b1, "abort_refetch");

        // Abort coinciding with memval: straight back to IDLE.
        instradr = 32'h0000_0300;
        instrreq = 1'b1;
        #1;
        tick();
        instrreq = 1'b0;
        #1;
        chk_b("abort_ack/memval", memval, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        chk_b("abort_ack/memreq", memreq, 1'b0);
        fetch(32'h0000_0300, 1'b1, "abort_ack_refetch");

        // Flush during refill: line completes but is invalid afterwards.
        mem_delay = 1;
        k         = 0;
        instradr  = 32'h0000_0080;
        instrreq  = 1'b1;
        #1;
        wait_acks(1, k);
        instrreq = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        if (memreq && memval) k++;
        wait_acks(WORDS, k);
        tick();
        #1;
        chk_b("flush_refill/memreq", memreq, 1'b0);
        fetch(32'h0000_0080, 1'b1, "flush_refill_refetch");
        fetch(32'h0000_0084, 1'b0, "flush_pre_hit");
        instradr = 32'h0000_0080;
        instrreq = 1'b1;
        flush    = 1'b1;
        #1;
        chk_b("flush_idle/hit", hit, 1'b0);
        chk("flush_idle/instr", instr, 32'd0);
        tick();
        flush    = 1'b0;
        instrreq = 1'b0;
        fetch(32'h0000_0088, 1'b1, "flush_idle_refetch");

        // Reset in the middle of a refill, then a stray memval.
        mem_delay = 0;
        fetch(32'h0000_00C0, 1'b1, "rmid_fill");
        fetch(32'h0000_00C4, 1'b0, "rmid_hit");
        mem_auto = 1'b0;
        memval   = 1'b0;
        instradr = 32'h0000_0500;
        instrreq = 1'b1;
        #1;
        tick();
        instrreq = 1'b0;
        #1;
        chk_b("rmid/refill_req", memreq, 1'b1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        instradr = 32'h0000_00C0;
        instrreq = 1'b1;
        #1;
        chk_b("rmid/memreq", memreq, 1'b0);
        chk("rmid/memadr", memadr, 32'd0);
        chk_b("rmid/hit", hit, 1'b0);
        instrreq = 1'b0;
        memval   = 1'b1;
        memdata  = 32'hDEAD_BEEF;
        tick();
        memval = 1'b0;
        #1;
        chk_b("rmid/late_memval", memreq, 1'b0);
        mem_auto = 1'b1;
        fetch(32'h0000_00C0, 1'b1, "rmid_refetch");

        // Randomized fetches against the residency model.
        do_reset();
        for (int i = 0; i < LINES; i++) m_val[i] = 1'b0;
        mem_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                for (int j = 0; j < LINES; j++) m_val[j] = 1'b0;
            end
            tg   = tag_pool[$urandom_range(0, 3)];
            adr  = (tg << 6) | (32'($urandom_range(0, LINES - 1)) << 4)
                 | (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(0, 3));
            line = adr / (4 * WORDS);
            idx  = line % LINES;
            tg   = line / LINES;
            fetch(adr, !(m_val[idx] && m_tag[idx] == tg), $sformatf("rnd%0d", i));
            m_val[idx] = 1'b1;
            m_tag[idx] = tg;
        end
        mem_rand = 1'b0;

`ifdef ICACHE_STATS_EN
        do_reset();
        chk("stats/hit0", hitcnt, 32'd0);
        chk("stats/miss0", misscnt, 32'd0);
        fetch(32'h0000_0000, 1'b1, "st_m0");
        fetch(32'h0000_0010, 1'b1, "st_m1");
        fetch(32'h0000_0020, 1'b1, "st_m2");
        for (int i = 0; i < 7; i++)
            fetch(32'(4 * (i % 3)) + 32'(16 * (i % 3)), 1'b0, $sformatf("st_h%0d", i));
        #1;
        chk("stats/hitcnt", hitcnt, 32'd10);
        chk("stats/misscnt", misscnt, 32'd3);
        do_reset();
        chk("stats/hit_rst", hitcnt, 32'd0);
        chk("stats/miss_rst", misscnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Parametrised direct-mapped instruction cache between the core's fetch port (instradr/instrreq/instr/hit/abort) and the instruction memory. It replaces the uncached fetch path: hits return in the request cycle, misses run a line-refill FSM against a single-outstanding-word memory handshake, and fetch redirects cancel refills cleanly. Line count and line length are parameters.

## Interface
- LINES, 16, number of cache lines; power of two, ≥2
- WORDS, 4, 32-bit words per line; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- instradr  in  32  fetch byte address from core; bits [1:0] ignored
- instrreq  in  1  fetch request, held by core until hit or abort
- instr  out  32  fetched instruction; 0 when hit=0
- hit  out  1  instr valid this cycle; request complete
- abort  in  1  core cancels current fetch (redirect)
- flush  in  1  invalidate all lines
- memadr  out  32  refill word byte address
- memreq  out  1  refill word request, held until memval
- memdata  in  32  returned word
- memval  in  1  memdata valid; completes one memreq
- hitcnt, misscnt  out  32  statistics (only with ICACHE_STATS_EN)

## Operation
- Address split: [1:0] byte, next log2(WORDS) bits word offset, next log2(LINES) index, remaining bits tag.
- Store: per line valid bit, tag, WORDS data words.
- States: IDLE, REFILL, DRAIN.
- IDLE: hit = instrreq & ~abort & ~flush & valid[idx] & tag match; instr = selected word. Miss (instrreq & ~abort & ~hit & ~flush): clear valid[idx], latch line base address and tag, wordcnt=0, go REFILL.
- REFILL: memreq=1, memadr = line base + 4*wordcnt. On memval: write memdata to word wordcnt; wordcnt++; on last word set valid, write tag, go IDLE. hit stays 0 in REFILL; core's retry hits in the first IDLE cycle.
- Abort in REFILL: if memval same cycle, accept nothing, go IDLE; else go DRAIN. Line stays invalid.
- DRAIN: memreq held at 1 (handshake must complete); on memval discard word, go IDLE.
- Abort in IDLE: no hit, no miss, no state change.
- Flush: in IDLE clears all valid bits that cycle, hit=0. Outside IDLE sets flush_pending; applied on entry to IDLE (the just-filled line is invalidated too).
- Reset mid-refill: immediate return to IDLE, memreq=0, all valid cleared; an in-flight memval after reset is ignored.

## Timing
- Reset values: state IDLE, memreq 0, memadr 0, hit 0, instr 0, all valid 0, wordcnt 0, flush_pending 0, counters 0.
- Hit latency 0 cycles (combinational from registered arrays).
- Miss latency: 1 (miss detect) + sum of memval waits for WORDS words + 1 (IDLE hit cycle).
- memreq, memadr registered; memadr advances the cycle after each memval; memreq may stay high across back-to-back words.
- memval while memreq=0 is ignored.

## Configuration
- ICACHE_STATS_EN defined: hitcnt increments on each hit cycle, misscnt on each IDLE→REFILL transition; 32-bit, wrap at 2^32; cleared by reset only (not flush).
- Undefined: hitcnt/misscnt ports absent; no counter logic.

## Structure
- Package icache_pkg: state enum typedef (IDLE, REFILL, DRAIN); functions/constants for offset, index and tag widths derived from LINES, WORDS.
- Sub-module icache_store: valid/tag/data arrays, one read port (index, word), one write port, bulk invalidate, single-line invalidate. FSM and address split stay in icache.

## Test plan
- Cold miss at 0x40 (LINES=16, WORDS=4): memadr 0x40,0x44,0x48,0x4C in order, memreq high throughout; then hit=1, instr = word at 0x40; next request 0x48 hits in 0 cycles.
- Conflict: fill 0x000, then fetch 0x100 (same index, different tag) -> miss, refill; refetch 0x000 -> miss again.
- Abort after 2nd memval with memval delayed 3 cycles: DRAIN holds memreq until memval, then IDLE; refetch same address -> full 4-word refill.
- Flush during REFILL: line completes, valid cleared on IDLE entry; refetch -> miss. Flush with instrreq in IDLE on a valid line -> hit=0.
- Reset asserted mid-refill: next cycle memreq=0, hit=0; late memval ignored; prior-hit address now misses.
- With ICACHE_STATS_EN: 3 misses + 10 hits -> misscnt=3, hitcnt=10; reset -> both 0.
